// File: rtl/prelu_inverse.sv
// ============================================================================
// prelu_inverse : iterative fixed-point inverse PReLU (x = y, or y / a for y < 0)
// Optional macro PRELU_INV_ROUND_EN rounds the quotient half away from zero.
// Rev 1.0
// ============================================================================
`default_nettype none

module prelu_inverse #(
  parameter int WIDTH = 32,
  parameter int FBITS = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x,
  output logic             div_zero,
  output logic             sat
);

  localparam int c_QW = WIDTH + FBITS;
  localparam int c_MW = c_QW + 1;
  localparam int c_CW = $clog2(c_QW + 1);

  localparam logic [c_CW-1:0]  c_STEPS   = c_CW'(c_QW);
  localparam logic [c_MW-1:0]  c_LIM     = c_MW'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] c_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] c_MAX     = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [c_QW-1:0]   r_dvd;
  logic [c_QW-1:0]   r_quo;
  logic [WIDTH:0]    r_rem;
  logic [WIDTH:0]    r_div;
  logic              r_neg;
  logic [WIDTH-1:0]  r_x;
  logic              r_ov;
  logic              r_dz;
  logic              r_sat;

  logic [WIDTH-1:0]  w_ymag;
  logic [WIDTH-1:0]  w_amag;
  logic [WIDTH:0]    w_trial;
  logic              w_ge;
  logic [WIDTH:0]    w_rem_nxt;
  logic [c_QW-1:0]   w_quo_nxt;
  logic [c_MW-1:0]   w_mag;
  logic [WIDTH-1:0]  w_res_x;
  logic              w_res_sat;

  // in_ready is forced low while reset is held, not just decoded from state
  assign in_ready  = rst_n && (r_state == S_IDLE);
  assign out_valid = r_ov;
  assign x         = r_x;
  assign div_zero  = r_dz;
  assign sat       = r_sat;

  always_comb begin
    w_ymag = y[WIDTH-1] ? (~y + 1'b1) : y;
    w_amag = a[WIDTH-1] ? (~a + 1'b1) : a;
  end

  // One restoring step; the remainder is always below the divisor, so its
  // top bit can be dropped before the shift.
  always_comb begin
    w_trial   = {r_rem[WIDTH-1:0], r_dvd[c_QW-1]};
    w_ge      = (w_trial >= r_div);
    w_rem_nxt = w_ge ? (w_trial - r_div) : w_trial;
    w_quo_nxt = {r_quo[c_QW-2:0], w_ge};
`ifdef PRELU_INV_ROUND_EN
    w_mag = {1'b0, w_quo_nxt}
          + c_MW'(({w_rem_nxt, 1'b0} >= {1'b0, r_div}) ? 1 : 0);
`else
    w_mag = {1'b0, w_quo_nxt};
`endif
  end

  // Negative results may reach exactly 2^(WIDTH-1) without clamping.
  always_comb begin
    w_res_x   = '0;
    w_res_sat = 1'b0;
    if (r_neg) begin
      if (w_mag > c_LIM) begin
        w_res_x   = c_MIN;
        w_res_sat = 1'b1;
      end else begin
        w_res_x = ~w_mag[WIDTH-1:0] + 1'b1;
      end
    end else begin
      if (w_mag >= c_LIM) begin
        w_res_x   = c_MAX;
        w_res_sat = 1'b1;
      end else begin
        w_res_x = w_mag[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_neg   <= 1'b0;
      r_x     <= '0;
      r_ov    <= 1'b0;
      r_dz    <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (!y[WIDTH-1]) begin
              r_x     <= y;
              r_dz    <= 1'b0;
              r_sat   <= 1'b0;
              r_ov    <= 1'b1;
              r_state <= S_DONE;
            end else if (a == '0) begin
              r_x     <= c_MIN;
              r_dz    <= 1'b1;
              r_sat   <= 1'b0;
              r_ov    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_dvd   <= c_QW'(w_ymag) << FBITS;
              r_div   <= {1'b0, w_amag};
              r_rem   <= '0;
              r_quo   <= '0;
              r_neg   <= y[WIDTH-1] ^ a[WIDTH-1];
              r_cnt   <= c_STEPS;
              r_state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_dvd <= r_dvd << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CW'(1)) begin
            r_x     <= w_res_x;
            r_sat   <= w_res_sat;
            r_dz    <= 1'b0;
            r_ov    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_ov    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prelu_inverse.sv
// ============================================================================
// tb_prelu_inverse : vector table + scoreboard bench for prelu_inverse
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prelu_inverse;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] x;
  logic        div_zero;
  logic        sat;

  int n_cmp;
  int n_err;
  int cyc;

  typedef struct {
    logic [31:0] y;
    logic [31:0] a;
    logic [31:0] x;
    logic        dz;
    logic        sat;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  prelu_inverse #(.WIDTH(32), .FBITS(27)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .div_zero  (div_zero),
    .sat       (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got no out_valid expected out_valid within budget", name);
  endtask

  task automatic add(input logic [31:0] vy, input logic [31:0] va, input logic [31:0] vx,
                     input logic vdz, input logic vsat, input int vlat);
    vec_t v;
    v.y = vy; v.a = va; v.x = vx; v.dz = vdz; v.sat = vsat; v.lat = vlat;
    vecs.push_back(v);
  endtask

  task automatic start(input vec_t v);
    @(negedge clk);
    y = v.y;
    a = v.a;
    in_valid = 1'b1;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(v);
  endtask

  // Returns 1 once out_valid is seen at a negedge, 0 after the budget expires.
  task automatic wait_out(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int   acc;
    bit   seen;
    start(v);
    acc = cyc;
    wait_out(seen);
    if (!seen) begin
      timeout($sformatf("vec%0d_timeout", idx));
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk($sformatf("vec%0d_x", idx), x, e.x);
      chk($sformatf("vec%0d_div_zero", idx), {31'd0, div_zero}, {31'd0, e.dz});
      chk($sformatf("vec%0d_sat", idx), {31'd0, sat}, {31'd0, e.sat});
      chk($sformatf("vec%0d_latency", idx), cyc - acc + 1, e.lat);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk($sformatf("vec%0d_in_ready_after", idx), {31'd0, in_ready}, 32'd1);
      chk($sformatf("vec%0d_out_valid_after", idx), {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    bit   seen;
    n_cmp = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; y = '0; a = '0;

    add(32'h0123_4567, 32'h0200_0000, 32'h0123_4567, 1'b0, 1'b0, 1);
    add(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
    add(32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1);
    add(32'hFC00_0000, 32'h0200_0000, 32'hF000_0000, 1'b0, 1'b0, 60);
    add(32'hF800_0000, 32'hFC00_0000, 32'h1000_0000, 1'b0, 1'b0, 60);
    add(32'hF800_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
    add(32'hC000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 60);
`ifdef PRELU_INV_ROUND_EN
    add(32'hFFFF_FFFF, 32'h0500_0000, 32'hFFFF_FFFE, 1'b0, 1'b0, 60);
    add(32'hFFFF_FFFF, 32'hFB00_0000, 32'h0000_0002, 1'b0, 1'b0, 60);
`else
    add(32'hFFFF_FFFF, 32'h0500_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 60);
    add(32'hFFFF_FFFF, 32'hFB00_0000, 32'h0000_0001, 1'b0, 1'b0, 60);
`endif
    add(32'h8000_0000, 32'h0800_0000, 32'h8000_0000, 1'b0, 1'b0, 60);
    add(32'h8000_0000, 32'hF800_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 60);
    add(32'hF800_0000, 32'hF800_0000, 32'h0800_0000, 1'b0, 1'b0, 60);
    add(32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 60);
    add(32'hFA00_0000, 32'h0300_0000, 32'hF000_0000, 1'b0, 1'b0, 60);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_x", x, 32'd0);
    chk("reset_flags", {30'd0, div_zero, sat}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Backpressure: result held for 10 cycles, in_valid pulses ignored
    start(vecs[3]);
    wait_out(seen);
    if (!seen) begin
      timeout("bp_timeout");
    end else begin
      for (int i = 0; i < 10; i++) begin
        in_valid = 1'b1;
        y = $urandom;
        a = $urandom;
        chk("bp_x", x, 32'hF000_0000);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp_x_end", x, 32'hF000_0000);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
      chk("bp_out_valid_release", {31'd0, out_valid}, 32'd0);
    end
    sb.delete();

    // Reset 20 cycles into a divide
    start(vecs[4]);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_x", x, 32'd0);
    chk("rst_mid_flags", {30'd0, div_zero, sat}, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (out_valid) chk("rst_stale_out_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("rst_idle_in_ready", {31'd0, in_ready}, 32'd1);
    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
